// File: rtl/ex_if.sv
// ex_if: ID/EX operand bundle into the execute stage and its write-back/forwarding/HI-LO results.
interface ex_if #(parameter int DATA_W = 32);
  logic              flush_i;
  logic [2:0]        alusel_i;
  logic [7:0]        aluop_i;
  logic [DATA_W-1:0] reg1_i;
  logic [DATA_W-1:0] reg2_i;
  logic [4:0]        waddr_i;
  logic              wreg_i;
  logic [DATA_W-1:0] wdata_o;
  logic [4:0]        waddr_o;
  logic              wreg_o;
  logic              whilo_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              stall_req_o;
  modport master (output flush_i, alusel_i, aluop_i, reg1_i, reg2_i, waddr_i, wreg_i,
                  input wdata_o, waddr_o, wreg_o, whilo_o, hi_o, lo_o, stall_req_o);
  modport slave  (input flush_i, alusel_i, aluop_i, reg1_i, reg2_i, waddr_i, wreg_i,
                  output wdata_o, waddr_o, wreg_o, whilo_o, hi_o, lo_o, stall_req_o);
endinterface

// File: rtl/ex_stage.sv
// ex_stage: combinational ALU plus radix-2 restoring divider that stalls upstream while busy.
module ex_stage #(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input logic clk,
  input logic rst,
  ex_if.slave ex
);
  localparam int SW = $clog2(DATA_W);
  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);
  localparam logic [2:0] SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010, SEL_ARITH = 3'b011, SEL_DIV = 3'b100;
  localparam logic [7:0] OP_OR = 8'h25, OP_AND = 8'h24, OP_XOR = 8'h26, OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
  localparam logic [7:0] OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLT = 8'h2A, OP_SLTU = 8'h2B, OP_DIV = 8'h1A;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic [DATA_W-1:0] alu_r, a_abs, b_abs;
  logic [DATA_W:0]   tmp, diff;
  logic [SW-1:0]     sh;
  logic              is_div, sgn, fits, live;

  assign sh     = ex.reg2_i[SW-1:0];
  assign is_div = ex.alusel_i == SEL_DIV;
  assign sgn    = ex.aluop_i == OP_DIV;
  assign a_abs  = sgn && ex.reg1_i[DATA_W-1] ? -ex.reg1_i : ex.reg1_i;
  assign b_abs  = sgn && ex.reg2_i[DATA_W-1] ? -ex.reg2_i : ex.reg2_i;
  assign tmp    = {rem_q, quo_q[DATA_W-1]};
  assign diff   = tmp - {1'b0, dvs_q};
  assign fits   = !diff[DATA_W];

  always_comb begin
    alu_r = '0;
    case ({ex.alusel_i, ex.aluop_i})
      {SEL_LOGIC, OP_OR}:   alu_r = ex.reg1_i | ex.reg2_i;
      {SEL_LOGIC, OP_AND}:  alu_r = ex.reg1_i & ex.reg2_i;
      {SEL_LOGIC, OP_XOR}:  alu_r = ex.reg1_i ^ ex.reg2_i;
      {SEL_LOGIC, OP_NOR}:  alu_r = ~(ex.reg1_i | ex.reg2_i);
      {SEL_SHIFT, OP_SLL}:  alu_r = ex.reg1_i << sh;
      {SEL_SHIFT, OP_SRL}:  alu_r = ex.reg1_i >> sh;
      {SEL_SHIFT, OP_SRA}:  alu_r = $unsigned($signed(ex.reg1_i) >>> sh);
      {SEL_ARITH, OP_ADDU}: alu_r = ex.reg1_i + ex.reg2_i;
      {SEL_ARITH, OP_SUBU}: alu_r = ex.reg1_i - ex.reg2_i;
      {SEL_ARITH, OP_SLT}:  alu_r = DATA_W'($signed(ex.reg1_i) < $signed(ex.reg2_i));
      {SEL_ARITH, OP_SLTU}: alu_r = DATA_W'(ex.reg1_i < ex.reg2_i);
      default:              alu_r = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    if (ex.flush_i) state_d = IDLE;
    else case (state_q)
      IDLE: if (is_div) begin
        // a zero divisor skips the loop; zeroed quotient/remainder make DONE report 0/0
        state_d = b_abs == '0 ? DONE : BUSY;
        cnt_d   = '0;
        rem_d   = '0;
        quo_d   = b_abs == '0 ? '0 : a_abs;
        dvs_d   = b_abs;
        qneg_d  = sgn && (ex.reg1_i[DATA_W-1] ^ ex.reg2_i[DATA_W-1]);
        rneg_d  = sgn && ex.reg1_i[DATA_W-1];
      end
      BUSY: begin
        rem_d   = fits ? diff[DATA_W-1:0] : tmp[DATA_W-1:0];
        quo_d   = {quo_q[DATA_W-2:0], fits};
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == LAST ? DONE : BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign live           = !rst && !ex.flush_i;
  assign ex.wdata_o     = rst ? '0 : alu_r;
  assign ex.waddr_o     = rst ? '0 : ex.waddr_i;
  assign ex.wreg_o      = live && !is_div && ex.wreg_i;
  assign ex.stall_req_o = live && (state_q == BUSY || (state_q == IDLE && is_div));
  assign ex.whilo_o     = live && state_q == DONE;
  assign ex.lo_o        = !ex.whilo_o ? '0 : qneg_q ? -quo_q : quo_q;
  assign ex.hi_o        = !ex.whilo_o ? '0 : rneg_q ? -rem_q : rem_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors with a cycle-tagged scoreboard checked by a negedge monitor.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_if #(.DATA_W(32)) bus();
  ex_stage #(.DATA_W(32), .DIV_CYCLES(32)) dut (.clk(clk), .rst(rst), .ex(bus));

  localparam logic [2:0] NOP = 3'b000, LOGIC = 3'b001, SHIFT = 3'b010, ARITH = 3'b011, DIVS = 3'b100;

  typedef struct {
    string       nm;
    int          cyc;
    logic [31:0] wdata;
    logic [4:0]  waddr;
    logic        wreg, whilo, stall;
    logic [31:0] hi, lo;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   d1, d2, dx;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      me = q.pop_front();
      checks++;
      if ({bus.wdata_o, bus.waddr_o, bus.wreg_o, bus.whilo_o, bus.stall_req_o, bus.hi_o, bus.lo_o} !==
          {me.wdata, me.waddr, me.wreg, me.whilo, me.stall, me.hi, me.lo}) begin
        failures++;
        $display("FAIL %s cyc=%0d got wdata=%h waddr=%0d wreg=%b whilo=%b stall=%b hi=%h lo=%h expected wdata=%h waddr=%0d wreg=%b whilo=%b stall=%b hi=%h lo=%h",
                 me.nm, cyc, bus.wdata_o, bus.waddr_o, bus.wreg_o, bus.whilo_o, bus.stall_req_o, bus.hi_o, bus.lo_o,
                 me.wdata, me.waddr, me.wreg, me.whilo, me.stall, me.hi, me.lo);
      end
    end else if (bus.whilo_o !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL spurious_whilo cyc=%0d got whilo=%b expected 0", cyc, bus.whilo_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic we);
    bus.alusel_i = sel;
    bus.aluop_i  = op;
    bus.reg1_i   = a;
    bus.reg2_i   = b;
    bus.waddr_i  = wa;
    bus.wreg_i   = we;
  endtask

  task automatic expect_now(input string nm, input logic [31:0] wd, input logic [4:0] wa, input logic wr,
                            input logic wh, input logic st, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.nm = nm; e.cyc = cyc; e.wdata = wd; e.waddr = wa; e.wreg = wr;
    e.whilo = wh; e.stall = st; e.hi = hi; e.lo = lo;
    q.push_back(e);
  endtask

  task automatic alu(input string nm, input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] wa, input logic [31:0] wd);
    drive(sel, op, a, b, wa, 1'b1);
    expect_now(nm, wd, wa, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic run_div(input string nm, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, output int done_cyc);
    drive(DIVS, op, a, b, 5'd9, 1'b1);
    for (int i = 0; i < (b == 32'h0 ? 1 : 33); i++) begin
      expect_now({nm, "_stall"}, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      step();
    end
    expect_now({nm, "_done"}, 32'h0, 5'd9, 1'b0, 1'b1, 1'b0, hi, lo);
    done_cyc = cyc;
    step();
    drive(NOP, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    bus.flush_i = 1'b0;
    drive(LOGIC, 8'h25, 32'h0000_1100, 32'h0000_0011, 5'd3, 1'b1);
    step();
    expect_now("reset_outputs", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    alu("or",    LOGIC, 8'h25, 32'h0000_1100, 32'h0000_0011, 5'd3, 32'h0000_1111);
    alu("and",   LOGIC, 8'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd4, 32'h00F0_1200);
    alu("xor",   LOGIC, 8'h26, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd5, 32'hF0F0_0F0F);
    alu("nor",   LOGIC, 8'h27, 32'h0000_0001, 32'h0000_0002, 5'd6, 32'hFFFF_FFFC);
    alu("sll",   SHIFT, 8'h7C, 32'h0000_0001, 32'h0000_0023, 5'd7, 32'h0000_0008);
    alu("srl",   SHIFT, 8'h02, 32'h8000_0000, 32'h0000_0004, 5'd8, 32'h0800_0000);
    alu("sra",   SHIFT, 8'h03, 32'h8000_0000, 32'h0000_0004, 5'd8, 32'hF800_0000);
    alu("addu",  ARITH, 8'h21, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1, 32'h0000_0001);
    alu("subu",  ARITH, 8'h23, 32'h0000_0000, 32'h0000_0001, 5'd2, 32'hFFFF_FFFF);
    alu("slt",   ARITH, 8'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 5'd10, 32'h0000_0001);
    alu("sltu",  ARITH, 8'h2B, 32'hFFFF_FFFF, 32'h0000_0001, 5'd11, 32'h0000_0000);
    alu("bad_op", LOGIC, 8'h99, 32'hFFFF_FFFF, 32'h1234_5678, 5'd12, 32'h0000_0000);
    alu("bad_sel", 3'b101, 8'h25, 32'hFFFF_FFFF, 32'h1234_5678, 5'd13, 32'h0000_0000);
    alu("nop",   NOP,   8'h00, 32'hFFFF_FFFF, 32'h1234_5678, 5'd14, 32'h0000_0000);

    run_div("div_neg", 8'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, dx);
    run_div("divu", 8'h1B, 32'd100, 32'd7, 32'd2, 32'd14, dx);
    run_div("div_negdvs", 8'h1A, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, dx);
    run_div("divu_zero", 8'h1B, 32'd55, 32'd0, 32'd0, 32'd0, dx);
    run_div("b2b_1", 8'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, d1);
    run_div("b2b_2", 8'h1B, 32'd100, 32'd7, 32'd2, 32'd14, d2);
    checks++;
    if (d2 - d1 != 34) begin
      failures++;
      $display("FAIL b2b_spacing got %0d cycles expected 34", d2 - d1);
    end

    drive(DIVS, 8'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9, 1'b1);
    for (int i = 0; i < 11; i++) begin
      expect_now("flush_pre", 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      step();
    end
    bus.flush_i = 1'b1;
    expect_now("flush_cycle", 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    bus.flush_i = 1'b0;
    alu("post_flush_idle", LOGIC, 8'h25, 32'h0000_1100, 32'h0000_0011, 5'd3, 32'h0000_1111);
    for (int i = 0; i < 3; i++) alu("post_flush_nop", NOP, 8'h00, 32'h0, 32'h0, 5'd0, 32'h0);

    drive(DIVS, 8'h1B, 32'd100, 32'd7, 5'd9, 1'b1);
    for (int i = 0; i < 6; i++) begin
      expect_now("rst_pre", 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      step();
    end
    rst = 1'b1;
    expect_now("rst_mid_busy", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    drive(NOP, 8'h00, 32'h0, 32'h0, 5'd4, 1'b1);
    rst = 1'b0;
    expect_now("rst_release", 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    run_div("post_rst_divu", 8'h1B, 32'd100, 32'd7, 32'd2, 32'd14, dx);
    alu("tail", NOP, 8'h00, 32'h0, 32'h0, 5'd0, 32'h0);
    step();

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
